fifo_sc_vr_reg_based: RTL and testbench
=======================================

// Module: fifo_sc_vr_reg_based
// PURPOSE
//  Single-clock, register-array FIFO with valid/ready handshakes on both sides.
//  - Depth need not be a power of two; head is shown first-word-fall-through (FWFT).
//  - Adds runtime almost-full/almost-empty thresholds, synchronous flush and a high-water mark.
//  - Drop-in successor for the request-style FIFOs between pipeline stages; producers/consumers no longer track full/empty.
// PARAMETERS
//  SIZE     8   number of entries, >=2, any integer
//  DATA_WD  32  entry width in bits
//  SIZE_WD  -   localparam = `FUNC_LOG2(SIZE); pointer width; counters are SIZE_WD+1 wide
// PORTS
//  clk        in   1            clock, all logic on posedge
//  rst        in   1            synchronous reset, active-high
//  clr_i      in   1            synchronous flush, active-high
//  wr_val_i   in   1            write valid
//  wr_rdy_o   out  1            write ready
//  wr_dat_i   in   DATA_WD      write data
//  rd_val_o   out  1            read valid (head entry present)
//  rd_rdy_i   in   1            read ready
//  rd_dat_o   out  DATA_WD      head entry data (FWFT)
//  afu_thr_i  in   SIZE_WD+1    almost-full threshold
//  aep_thr_i  in   SIZE_WD+1    almost-empty threshold
//  afu_o      out  1            almost full
//  aep_o      out  1            almost empty
//  wd_usd_o   out  SIZE_WD+1    entries currently stored
//  wd_max_o   out  SIZE_WD+1    high-water mark of wd_usd_o since reset/flush
// BEHAVIOUR
//  - Reset (rst=1, one or more cycles):
//    - wr_adr, rd_adr, wd_usd_o and wd_max_o go to 0; array contents are not reset.
//    - wr_rdy_o=0 and rd_val_o=0 while rst=1; wr_rdy_o=1 on the first cycle after rst falls.
//  - Push = wr_val_i & wr_rdy_o; pop = rd_val_o & rd_rdy_i.
//  - Ready/valid rules:
//    - wr_rdy_o = !full & !clr_i & !rst. It has no combinational dependence on rd_rdy_i, so a full FIFO stalls even when popping.
//    - rd_val_o = (wd_usd_o!=0) & !clr_i & !rst.
//    - wr_val_i may be held while waiting; data is sampled only on push.
//  - Latency: a push into an empty FIFO gives rd_val_o=1 on the next cycle; rd_dat_o = array[rd_adr] combinationally.
//  - Pointers: each advances by 1 on its event and wraps SIZE-1 -> 0 (explicit compare, not modulo 2^SIZE_WD).
//  - Count: wd_usd_o +1 on push only, -1 on pop only, unchanged on push&pop. Push&pop at full is impossible by construction.
//  - Flush: clr_i=1 sets pointers, wd_usd_o and wd_max_o to 0 next cycle, overriding any push/pop that cycle. Handshakes are suppressed during clr_i, so no data is lost silently.
//  - Flags (combinational from registered count):
//    - afu_o = wd_usd_o >= afu_thr_i; afu_thr_i=0 keeps afu_o=1.
//    - aep_o = wd_usd_o <= aep_thr_i.
//    - Thresholds above SIZE are legal: afu_o then never asserts and aep_o always asserts.
//  - High-water mark: wd_max_o <= max(wd_max_o, next wd_usd_o), so it tracks the count in the same cycle; it is never decremented except by rst/clr_i.
//  - Full/empty: full = wd_usd_o==SIZE, empty = wd_usd_o==0. Overflow and underflow cannot occur through the handshake.
// CONFIGURATION
//  FIFO_SC_VR_BYPASS_EN defined:
//  - When empty, rd_val_o = wr_val_i & !clr_i & !rst and rd_dat_o = wr_dat_i (zero-latency cut-through).
//  - Push&pop in that cycle stores nothing and leaves the count at 0.
//  - Push without pop stores the data normally.
//  - wr_rdy_o is unchanged.
//  FIFO_SC_VR_BYPASS_EN undefined: behaviour as above; write-to-read latency is exactly 1 cycle; no combinational path from wr_* to rd_*.
// TESTING
//  1 SIZE=5: push 0x11..0x15 back-to-back with rd_rdy_i=0
//    -> wr_rdy_o=0 after 5th push, wd_usd_o=5, wd_max_o=5.
//    -> then rd_rdy_i=1 drains 0x11..0x15 in order; wd_usd_o reaches 0; wd_max_o stays 5.
//  2 SIZE=5: 12 pushes and pops interleaved, with a 2-entry steady state -> pointers wrap 4->0 twice, data in order, no loss.
//  3 Full FIFO, wr_val_i=1 and rd_rdy_i=1 for 1 cycle
//    -> pop only, wr_rdy_o=0 in that cycle, wd_usd_o=SIZE-1.
//    -> push accepted on the next cycle.
//  4 afu_thr_i=3, aep_thr_i=1, ramp count 0->4->0
//    -> afu_o=1 exactly when count is 3..4.
//    -> aep_o=1 exactly when count is 0..1.
//  5 With 3 entries, clr_i=1 for 1 cycle while wr_val_i=1
//    -> wr_rdy_o=0 and rd_val_o=0 in that cycle.
//    -> next cycle wd_usd_o=0, wd_max_o=0; the new write is accepted after that.
//  6 Empty FIFO, push 0xA5 with rd_rdy_i=1
//    -> BYPASS_EN: rd_val_o=1, rd_dat_o=0xA5 in the same cycle, count stays 0.
//    -> otherwise: rd_val_o=1 on the next cycle.
//    -> rst mid-stream: rd_val_o=0 the cycle after rst rises.

Source files
------------

// File: rtl/fifo_sc_vr_reg_based.sv
// fifo_sc_vr_reg_based
//   Single-clock FIFO built from a register array, valid/ready on both sides,
//   first-word-fall-through head. Depth may be any integer >= 2. Provides runtime
//   almost-full/almost-empty flags, a synchronous flush and a high-water mark.
//
// Optional feature macro: FIFO_SC_VR_BYPASS_EN
//   When defined, an empty FIFO passes write data straight to the read side in the
//   same cycle (cut-through); a simultaneous push and pop stores nothing.
//
// Parameters
//   SIZE     number of entries (>= 2)
//   DATA_WD  entry width in bits
//   SIZE_WD  pointer width; counters are SIZE_WD+1 wide
//
// Ports
//   clk        clock, all state on posedge
//   rst        synchronous reset, active-high
//   clr_i      synchronous flush, active-high
//   wr_val_i   write valid          wr_rdy_o   write ready
//   wr_dat_i   write data
//   rd_val_o   read valid           rd_rdy_i   read ready
//   rd_dat_o   head entry data
//   afu_thr_i  almost-full threshold   afu_o  wd_usd_o >= afu_thr_i
//   aep_thr_i  almost-empty threshold  aep_o  wd_usd_o <= aep_thr_i
//   wd_usd_o   entries stored
//   wd_max_o   high-water mark of wd_usd_o since reset/flush
module fifo_sc_vr_reg_based #(
    parameter int unsigned  SIZE    = 8,
    parameter int unsigned  DATA_WD = 32,
    localparam int unsigned SIZE_WD = $clog2(SIZE)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr_i,
    input  logic               wr_val_i,
    output logic               wr_rdy_o,
    input  logic [DATA_WD-1:0] wr_dat_i,
    output logic               rd_val_o,
    input  logic               rd_rdy_i,
    output logic [DATA_WD-1:0] rd_dat_o,
    input  logic [SIZE_WD:0]   afu_thr_i,
    input  logic [SIZE_WD:0]   aep_thr_i,
    output logic               afu_o,
    output logic               aep_o,
    output logic [SIZE_WD:0]   wd_usd_o,
    output logic [SIZE_WD:0]   wd_max_o
);

    localparam logic [SIZE_WD-1:0] PTR_LAST = SIZE_WD'(SIZE - 1);
    localparam logic [SIZE_WD:0]   CNT_FULL = (SIZE_WD + 1)'(SIZE);

    logic [DATA_WD-1:0] mem_q [SIZE];
    logic [SIZE_WD-1:0] wr_adr_q, wr_adr_d;
    logic [SIZE_WD-1:0] rd_adr_q, rd_adr_d;
    logic [SIZE_WD:0]   usd_q, usd_d;
    logic [SIZE_WD:0]   max_q, max_d;

    logic full, empty, push, pop, store, take, byp;

    assign full  = (usd_q == CNT_FULL);
    assign empty = (usd_q == '0);

    // Ready never looks at rd_rdy_i: a full FIFO stalls even while being popped.
    assign wr_rdy_o = !full && !clr_i && !rst;
    assign push     = wr_val_i && wr_rdy_o;
    assign pop      = rd_val_o && rd_rdy_i;

`ifdef FIFO_SC_VR_BYPASS_EN
    assign rd_val_o = (empty ? wr_val_i : 1'b1) && !clr_i && !rst;
    assign rd_dat_o = empty ? wr_dat_i : mem_q[rd_adr_q];
    // Cut-through beat: data goes straight out and never touches the array.
    assign byp      = empty && push && pop;
`else
    assign rd_val_o = !empty && !clr_i && !rst;
    assign rd_dat_o = mem_q[rd_adr_q];
    assign byp      = 1'b0;
`endif

    assign store = push && !byp;
    assign take  = pop && !byp;

    always_comb begin
        wr_adr_d = wr_adr_q;
        rd_adr_d = rd_adr_q;
        usd_d    = usd_q;
        max_d    = max_q;
        if (clr_i) begin
            wr_adr_d = '0;
            rd_adr_d = '0;
            usd_d    = '0;
            max_d    = '0;
        end else begin
            if (store) begin
                wr_adr_d = (wr_adr_q == PTR_LAST) ? '0 : wr_adr_q + 1'b1;
            end
            if (take) begin
                rd_adr_d = (rd_adr_q == PTR_LAST) ? '0 : rd_adr_q + 1'b1;
            end
            if (store && !take) begin
                usd_d = usd_q + 1'b1;
            end else if (take && !store) begin
                usd_d = usd_q - 1'b1;
            end
            // Compare against the next count so the mark follows in the same cycle.
            if (usd_d > max_q) begin
                max_d = usd_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_adr_q <= '0;
            rd_adr_q <= '0;
            usd_q    <= '0;
            max_q    <= '0;
        end else begin
            wr_adr_q <= wr_adr_d;
            rd_adr_q <= rd_adr_d;
            usd_q    <= usd_d;
            max_q    <= max_d;
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (store) begin
            mem_q[wr_adr_q] <= wr_dat_i;
        end
    end

    assign afu_o    = (usd_q >= afu_thr_i);
    assign aep_o    = (usd_q <= aep_thr_i);
    assign wd_usd_o = usd_q;
    assign wd_max_o = max_q;

endmodule

// File: tb/tb_fifo_sc_vr_reg_based.sv
// tb_fifo_sc_vr_reg_based
//   Directed self-checking bench for fifo_sc_vr_reg_based with SIZE=5, DATA_WD=8.
//   Inputs change 1 time unit after the rising edge; outputs are checked before the
//   next rising edge.
module tb_fifo_sc_vr_reg_based;

    localparam int unsigned SIZE    = 5;
    localparam int unsigned DATA_WD = 8;
    localparam int unsigned SIZE_WD = $clog2(SIZE);

    logic               clk = 1'b0;
    logic               rst;
    logic               clr_i;
    logic               wr_val_i;
    logic               wr_rdy_o;
    logic [DATA_WD-1:0] wr_dat_i;
    logic               rd_val_o;
    logic               rd_rdy_i;
    logic [DATA_WD-1:0] rd_dat_o;
    logic [SIZE_WD:0]   afu_thr_i;
    logic [SIZE_WD:0]   aep_thr_i;
    logic               afu_o;
    logic               aep_o;
    logic [SIZE_WD:0]   wd_usd_o;
    logic [SIZE_WD:0]   wd_max_o;

    int n_assert = 0;
    int n_fail   = 0;

    fifo_sc_vr_reg_based #(
        .SIZE    (SIZE),
        .DATA_WD (DATA_WD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (clr_i),
        .wr_val_i  (wr_val_i),
        .wr_rdy_o  (wr_rdy_o),
        .wr_dat_i  (wr_dat_i),
        .rd_val_o  (rd_val_o),
        .rd_rdy_i  (rd_rdy_i),
        .rd_dat_o  (rd_dat_o),
        .afu_thr_i (afu_thr_i),
        .aep_thr_i (aep_thr_i),
        .afu_o     (afu_o),
        .aep_o     (aep_o),
        .wd_usd_o  (wd_usd_o),
        .wd_max_o  (wd_max_o)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst       = 1'b1;
        clr_i     = 1'b0;
        wr_val_i  = 1'b0;
        wr_dat_i  = '0;
        rd_rdy_i  = 1'b0;
        afu_thr_i = 4'd5;
        aep_thr_i = 4'd0;

        // Reset
        cyc();
        wr_val_i = 1'b1;
        #1;
        chk("rst_wr_rdy", 32'(wr_rdy_o), 0);
        chk("rst_rd_val", 32'(rd_val_o), 0);
        wr_val_i = 1'b0;
        cyc();
        chk("rst_usd", 32'(wd_usd_o), 0);
        chk("rst_max", 32'(wd_max_o), 0);
        rst = 1'b0;
        #1;
        chk("post_rst_wr_rdy", 32'(wr_rdy_o), 1);
        chk("post_rst_rd_val", 32'(rd_val_o), 0);

        // 1: fill 0x11..0x15 with no reads, then drain
        for (int i = 0; i < 5; i++) begin
            wr_val_i = 1'b1;
            wr_dat_i = 8'(8'h11 + i);
            #1;
            chk("t1_wr_rdy", 32'(wr_rdy_o), 1);
            cyc();
            chk("t1_usd", 32'(wd_usd_o), 32'(i + 1));
        end
        wr_dat_i = 8'h99;
        #1;
        chk("t1_full_wr_rdy", 32'(wr_rdy_o), 0);
        cyc();
        chk("t1_full_usd", 32'(wd_usd_o), 5);
        chk("t1_full_max", 32'(wd_max_o), 5);
        wr_val_i = 1'b0;
        rd_rdy_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t1_rd_val", 32'(rd_val_o), 1);
            chk("t1_rd_dat", 32'(rd_dat_o), 32'(8'h11 + i));
            cyc();
        end
        chk("t1_empty_usd", 32'(wd_usd_o), 0);
        chk("t1_empty_max", 32'(wd_max_o), 5);
        chk("t1_empty_rd_val", 32'(rd_val_o), 0);
        rd_rdy_i = 1'b0;

        // 2: 12 pushes with a 2-entry steady state, write pointer wraps twice
        wr_val_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            wr_dat_i = 8'(8'h20 + i);
            cyc();
        end
        chk("t2_prefill_usd", 32'(wd_usd_o), 2);
        rd_rdy_i = 1'b1;
        for (int k = 0; k < 10; k++) begin
            wr_dat_i = 8'(8'h22 + k);
            #1;
            chk("t2_rd_dat", 32'(rd_dat_o), 32'(8'h20 + k));
            cyc();
            chk("t2_usd", 32'(wd_usd_o), 2);
        end
        wr_val_i = 1'b0;
        for (int k = 10; k < 12; k++) begin
            #1;
            chk("t2_tail_dat", 32'(rd_dat_o), 32'(8'h20 + k));
            cyc();
        end
        chk("t2_empty_usd", 32'(wd_usd_o), 0);
        rd_rdy_i = 1'b0;

        // 3: full with simultaneous write and read request
        wr_val_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wr_dat_i = 8'(8'h30 + i);
            cyc();
        end
        wr_dat_i = 8'h35;
        rd_rdy_i = 1'b1;
        #1;
        chk("t3_wr_rdy_full", 32'(wr_rdy_o), 0);
        chk("t3_rd_dat", 32'(rd_dat_o), 32'h30);
        cyc();
        chk("t3_usd_pop_only", 32'(wd_usd_o), 4);
        rd_rdy_i = 1'b0;
        #1;
        chk("t3_wr_rdy_next", 32'(wr_rdy_o), 1);
        cyc();
        chk("t3_usd_refill", 32'(wd_usd_o), 5);
        wr_val_i = 1'b0;
        rd_rdy_i = 1'b1;
        for (int i = 1; i < 6; i++) begin
            #1;
            chk("t3_drain_dat", 32'(rd_dat_o), 32'(8'h30 + i));
            cyc();
        end
        chk("t3_empty_usd", 32'(wd_usd_o), 0);
        rd_rdy_i = 1'b0;

        // 4: thresholds afu=3, aep=1, ramp 0->4->0
        afu_thr_i = 4'd3;
        aep_thr_i = 4'd1;
        for (int c = 0; c <= 4; c++) begin
            #1;
            chk("t4_up_afu", 32'(afu_o), (c >= 3) ? 1 : 0);
            chk("t4_up_aep", 32'(aep_o), (c <= 1) ? 1 : 0);
            if (c < 4) begin
                wr_val_i = 1'b1;
                wr_dat_i = 8'(8'h40 + c);
                cyc();
                wr_val_i = 1'b0;
            end
        end
        for (int c = 3; c >= 0; c--) begin
            rd_rdy_i = 1'b1;
            cyc();
            rd_rdy_i = 1'b0;
            #1;
            chk("t4_dn_afu", 32'(afu_o), (c >= 3) ? 1 : 0);
            chk("t4_dn_aep", 32'(aep_o), (c <= 1) ? 1 : 0);
        end
        afu_thr_i = 4'd0;
        aep_thr_i = 4'd6;
        #1;
        chk("t4_afu_thr0", 32'(afu_o), 1);
        chk("t4_aep_thr6", 32'(aep_o), 1);
        afu_thr_i = 4'd6;
        #1;
        chk("t4_afu_thr6", 32'(afu_o), 0);
        afu_thr_i = 4'd5;
        aep_thr_i = 4'd0;

        // 5: flush with 3 entries while writing
        wr_val_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_dat_i = 8'(8'h40 + i);
            cyc();
        end
        chk("t5_pre_usd", 32'(wd_usd_o), 3);
        clr_i    = 1'b1;
        wr_dat_i = 8'h50;
        #1;
        chk("t5_clr_wr_rdy", 32'(wr_rdy_o), 0);
        chk("t5_clr_rd_val", 32'(rd_val_o), 0);
        cyc();
        clr_i = 1'b0;
        chk("t5_post_usd", 32'(wd_usd_o), 0);
        chk("t5_post_max", 32'(wd_max_o), 0);
        #1;
        chk("t5_post_wr_rdy", 32'(wr_rdy_o), 1);
        cyc();
        wr_val_i = 1'b0;
        chk("t5_new_usd", 32'(wd_usd_o), 1);
        chk("t5_new_max", 32'(wd_max_o), 1);
        chk("t5_new_dat", 32'(rd_dat_o), 32'h50);
        rd_rdy_i = 1'b1;
        cyc();
        chk("t5_drain_usd", 32'(wd_usd_o), 0);

        // 6: push 0xA5 into an empty FIFO with the reader ready
        wr_val_i = 1'b1;
        wr_dat_i = 8'hA5;
        #1;
`ifdef FIFO_SC_VR_BYPASS_EN
        chk("t6_byp_rd_val", 32'(rd_val_o), 1);
        chk("t6_byp_rd_dat", 32'(rd_dat_o), 32'hA5);
        cyc();
        wr_val_i = 1'b0;
        chk("t6_byp_usd", 32'(wd_usd_o), 0);
        #1;
        chk("t6_byp_rd_val_after", 32'(rd_val_o), 0);
`else
        chk("t6_rd_val_same", 32'(rd_val_o), 0);
        cyc();
        wr_val_i = 1'b0;
        chk("t6_usd", 32'(wd_usd_o), 1);
        #1;
        chk("t6_rd_val_next", 32'(rd_val_o), 1);
        chk("t6_rd_dat_next", 32'(rd_dat_o), 32'hA5);
        cyc();
        chk("t6_usd_drained", 32'(wd_usd_o), 0);
`endif
        rd_rdy_i = 1'b0;

        // Reset mid-stream
        wr_val_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            wr_dat_i = 8'(8'h60 + i);
            cyc();
        end
        wr_val_i = 1'b0;
        #1;
        chk("rst2_pre_rd_val", 32'(rd_val_o), 1);
        rst = 1'b1;
        cyc();
        chk("rst2_rd_val", 32'(rd_val_o), 0);
        chk("rst2_wr_rdy", 32'(wr_rdy_o), 0);
        chk("rst2_usd", 32'(wd_usd_o), 0);
        chk("rst2_max", 32'(wd_max_o), 0);
        rst = 1'b0;
        #1;
        chk("rst2_release_wr_rdy", 32'(wr_rdy_o), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
